// File: rtl/shift_add_mult_seq.sv
// shift_add_mult_seq: sequential shift-and-add multiplier.
// Operands load on an accepted start. One multiplier bit (LSB first) is retired
// per clock. The 2*WIDTH-bit product is registered and flagged with a one-cycle
// o_valid pulse.
// Optional build macro SHIFT_ADD_SIGNED_EN adds i_signed, which selects
// two's-complement operands for that operation.
module shift_add_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
`ifdef SHIFT_ADD_SIGNED_EN
    input  logic                   i_signed,
`endif
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [2*WIDTH-1:0]     o_product
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       sum;
    logic                 last_iter;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SHIFT_ADD_SIGNED_EN
    logic signed_q, signed_d;
    logic acc_sx, b_sx;

    // N+1-bit partial-product adder; in signed mode the final (MSB) multiplier
    // bit has negative weight, so B is subtracted instead of added.
    always_comb begin
        acc_sx = signed_q & acc_q[WIDTH-1];
        b_sx   = signed_q & b_q[WIDTH-1];
        if (!a_q[0]) begin
            sum = {acc_sx, acc_q};
        end else if (signed_q && last_iter) begin
            sum = {acc_sx, acc_q} - {b_sx, b_q};
        end else begin
            sum = {acc_sx, acc_q} + {b_sx, b_q};
        end
    end
`else
    // N+1-bit partial-product adder; the extra bit holds the carry.
    always_comb begin
        sum = {1'b0, acc_q};
        if (a_q[0]) begin
            sum = {1'b0, acc_q} + {1'b0, b_q};
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
`ifdef SHIFT_ADD_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
`ifdef SHIFT_ADD_SIGNED_EN
            signed_q <= signed_d;
`endif
        end
    end

    // Next-state logic: load on start, shift {ACC,A} right once per RUN cycle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
`ifdef SHIFT_ADD_SIGNED_EN
        signed_d = signed_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d      = i_a;
                    b_d      = i_b;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef SHIFT_ADD_SIGNED_EN
                    signed_d = i_signed;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d = sum[WIDTH:1];
                a_d   = {sum[0], a_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    // Capture the post-shift {ACC,A} directly so the product
                    // register is valid in the same cycle as o_valid.
                    prod_d  = {sum, a_q[WIDTH-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready   = (state_q == IDLE);
    assign o_busy    = (state_q == RUN) || (state_q == DONE);
    assign o_valid   = (state_q == DONE);
    assign o_product = prod_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Testbench for shift_add_mult_seq: directed vectors with literal expectations
// plus a cycle-timing reference model compared on every falling edge.
module tb_shift_add_mult_seq;

    localparam int unsigned W = 8;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic             sgn_in = 1'b0;
    logic [W-1:0]     a      = '0;
    logic [W-1:0]     b      = '0;
    logic             o_ready, o_busy, o_valid;
    logic [2*W-1:0]   o_product;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_add_mult_seq #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_a       (a),
        .i_b       (b),
`ifdef SHIFT_ADD_SIGNED_EN
        .i_signed  (sgn_in),
`endif
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_product (o_product)
    );

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] model_mult(input logic [W-1:0] x,
                                                  input logic [W-1:0] y,
                                                  input logic s);
        longint px;
        if (s) px = longint'($signed(x)) * longint'($signed(y));
        else   px = longint'(x) * longint'(y);
        return px[2*W-1:0];
    endfunction

    // Reference model: a countdown of remaining busy cycles after an accepted
    // start; the result appears when one cycle remains.
    int             m_left = 0;
    logic [2*W-1:0] m_pend = '0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_prod <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= W + 1;
                m_pend <= model_mult(a, b, sgn_in);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_prod <= m_pend;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        chk("model_ready",   32'(o_ready),   32'(m_left == 0));
        chk("model_busy",    32'(o_busy),    32'(m_left != 0));
        chk("model_valid",   32'(o_valid),   32'(m_left == 1));
        chk("model_product", 32'(o_product), 32'(m_prod));
    end

    // Start one multiplication from IDLE and check latency and product.
    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic [2*W-1:0] exp, input string nm);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        @(posedge clk); #2;
        a = x; b = y; sgn_in = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (o_valid) begin
                lat  = c;
                seen = 1;
                break;
            end
        end
        chk({nm, "_valid_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"},    32'(lat),  32'd9);
        chk({nm, "_product"},    32'(o_product), 32'(exp));
        @(negedge clk);
        chk({nm, "_ready_after"}, 32'(o_ready), 32'd1);
    endtask

    // Count o_valid pulses over a window of cycles.
    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (o_valid) n++;
        end
    endtask

    initial begin
        int n;
        bit seen;

        // Reset
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",   32'(o_ready),   32'd1);
        chk("rst_busy",    32'(o_busy),    32'd0);
        chk("rst_valid",   32'(o_valid),   32'd0);
        chk("rst_product", 32'(o_product), 32'd0);

        // Pin the model itself
        chk("model_pin_u", 32'(model_mult(8'd13, 8'd11, 1'b0)), 32'h008F);
        chk("model_pin_s", 32'(model_mult(8'hFD, 8'd5, 1'b1)),  32'hFFF1);

        // Basic, max/carry, zero
        run(8'd13,  8'd11,  1'b0, 16'h008F, "basic");
        run(8'd255, 8'd255, 1'b0, 16'hFE01, "max");
        run(8'd0,   8'd200, 1'b0, 16'h0000, "zero");
        run(8'd1,   8'd128, 1'b0, 16'h0080, "one");

        // Busy rejection: second start during RUN must be ignored
        @(posedge clk); #2;
        a = 8'd6; b = 8'd7; sgn_in = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 a = 8'd9; b = 8'd9; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1;
                break;
            end
        end
        chk("busy_valid_seen", 32'(seen), 32'd1);
        chk("busy_product",    32'(o_product), 32'd42);
        count_valid(20, n);
        chk("busy_no_second_valid", 32'(n), 32'd0);
        chk("busy_product_held",    32'(o_product), 32'd42);

        // Reset mid-operation
        @(posedge clk); #2;
        a = 8'd100; b = 8'd100; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        count_valid(15, n);
        chk("abort_no_valid", 32'(n), 32'd0);
        chk("abort_product",  32'(o_product), 32'd0);
        chk("abort_ready",    32'(o_ready), 32'd1);
        run(8'd3, 8'd4, 1'b0, 16'd12, "after_abort");

`ifdef SHIFT_ADD_SIGNED_EN
        run(8'hFD, 8'd5,  1'b1, 16'hFFF1, "s_neg3x5");
        run(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_sq");
        run(8'hFD, 8'd5,  1'b0, 16'h04F1, "s_off");
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_seq.md
Name: shift_add_mult_seq

Overview:
- Parametrised sequential shift-and-add multiplier. Controller FSM, multiplicand/multiplier/accumulator registers and adder are integrated in one block.
- Both operands load in parallel on a start handshake. One partial product is processed per clock. The full 2N-bit product is presented with a valid pulse.
- Successor to the 8-bit externally-sequenced datapath. It sits between a host register interface and downstream consumers of the product.

Parameters:
- WIDTH, 8, operand width N in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width. Derived; not to be overridden.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request; accepted only when o_ready=1.
- i_a  input  WIDTH  multiplier; its bits are consumed LSB first.
- i_b  input  WIDTH  multiplicand.
- o_ready  output  1  block idle, able to accept i_start.
- o_busy  output  1  multiplication in progress.
- o_valid  output  1  one-cycle pulse; o_product is complete.
- o_product  output  2*WIDTH  product; held stable until the next accepted start.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; ACC, A, B and counter cleared.
  - o_ready=1, o_busy=0, o_valid=0, o_product=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with i_start=1: A<=i_a, B<=i_b, ACC<=0, cnt<=0, go to RUN.
  - i_a and i_b are sampled only on that edge.
- RUN, each edge:
  - sum[N:0] = {0,ACC} + (A[0] ? {0,B} : 0), N+1 bits. sum[N] is the carry.
  - {ACC,A} <= {sum[N:0], A[N-1:1]}, i.e. shift right by one with the carry shifted into the ACC MSB.
  - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, go to DONE.
- DONE:
  - o_product={ACC,A}, o_valid=1 for exactly this one cycle.
  - Next edge returns to IDLE.
- Outputs:
  - o_product is registered. It updates on the edge entering DONE and is held through IDLE.
  - o_ready=1 only in IDLE; o_busy=1 in RUN and DONE.
- Latency: start accepted at edge k, o_valid high in the cycle after edge k+WIDTH. This is WIDTH+1 cycles. Throughput is one product per WIDTH+2 cycles.
- i_start while busy (RUN or DONE): ignored; no queueing; operands not resampled.
- Back-to-back: i_start held high through DONE is accepted in the following IDLE cycle.
- Reset mid-operation: immediate abort. All state returns to reset values, including o_product=0, and no o_valid is produced.
- Width rule: the product never overflows 2N bits. The carry is never lost because the adder is N+1 bits.
- Zero operands take the full WIDTH iterations; there is no early termination.

Optional Feature:
- Macro SHIFT_ADD_SIGNED_EN.
- Defined:
  - Adds input port i_signed (1 bit), sampled with the operands at start.
  - When the latched flag is 1, operands are two's complement:
    - the addend is sign-extended B to N+1 bits;
    - ACC is treated as signed N+1;
    - on the final iteration (cnt==WIDTH-1) with A[0]=1, sum=ACC-B instead of ACC+B, because the multiplier MSB carries negative weight;
    - the bit shifted into the ACC MSB is sum[N] (the true sign).
  - When the latched flag is 0, behaviour is identical to the unsigned mode.
- Undefined: no i_signed port; unsigned only. Latency is unchanged in both builds.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles, release -> o_ready=1, o_busy=0, o_valid=0, o_product=0.
- Basic: WIDTH=8, i_a=13, i_b=11, pulse i_start -> o_valid high exactly 9 cycles after the start edge, o_product=16'h008F, o_ready returns 1 one cycle later.
- Max and carry: i_a=255, i_b=255 -> o_product=16'hFE01. Then i_a=0, i_b=200 -> o_product=0, still 9-cycle latency.
- Busy rejection: start 6*7, then pulse i_start with i_a=9, i_b=9 at cycle 3 -> single o_valid, o_product=16'd42. No second result until a new start in IDLE.
- Reset mid-op: start 100*100, assert i_rst_n=0 at cycle 4 for 1 cycle -> o_product=0, no o_valid. Next start 3*4 -> o_product=12.
- Signed (SHIFT_ADD_SIGNED_EN, i_signed=1):
  - i_a=8'hFD (-3), i_b=5 -> 16'hFFF1.
  - i_a=8'h80, i_b=8'h80 -> 16'h4000.
  - Same i_a=8'hFD, i_b=5 with i_signed=0 -> 16'h04F1.
